// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg
// Shared definitions for the crossbar read/write arbiters:
//   - slave address decode table (SLV_BASE / SLV_MASK), one entry per real slave
//   - DEFAULT_SLV: index of the DECERR slave (one past the last real slave)
//   - arb_state_e: arbiter FSM states
//   - ARB_FIXED / ARB_RR: arbitration policy selectors
package axi_arb_pkg;

  localparam int SLV_TBL_N   = 8;
  localparam int DEFAULT_SLV = SLV_TBL_N;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Each real slave owns a 64 KiB window at s * 0x1_0000.
  localparam logic [31:0] SLV_BASE [SLV_TBL_N] = '{
    32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
    32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'h0007_0000
  };

  localparam logic [31:0] SLV_MASK [SLV_TBL_N] = '{
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_param_if.sv
// axi_rd_arbiter_param_if
// Read-arbiter bus bundle between the crossbar and the arbiter.
//   master modport : crossbar side (drives AR requests, muxed handshakes, write busy)
//   slave modport  : arbiter side (drives registered grant outputs and timeout pulse)
interface axi_rd_arbiter_param_if #(
  parameter int NUM_M  = 3,
  parameter int NUM_S  = 8,
  parameter int ADDR_W = 32
);
  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = $clog2(NUM_S + 1);

  logic [NUM_M-1:0]        ARVALID_M;
  logic [NUM_M*ADDR_W-1:0] ARADDR_M;
  logic                    ARREADY_sel;
  logic                    RVALID_sel;
  logic                    RREADY_sel;
  logic                    RLAST_sel;
  logic [NUM_S:0]          wr_busy_slv;
  logic                    rd_grant_vld;
  logic [MW-1:0]           rd_grant_mst;
  logic [SW-1:0]           rd_grant_slv;
  logic [NUM_M-1:0]        rd_grant_oh;
  logic                    rd_timeout;

  modport master (
    output ARVALID_M, ARADDR_M, ARREADY_sel, RVALID_sel, RREADY_sel, RLAST_sel, wr_busy_slv,
    input  rd_grant_vld, rd_grant_mst, rd_grant_slv, rd_grant_oh, rd_timeout
  );

  modport slave (
    input  ARVALID_M, ARADDR_M, ARREADY_sel, RVALID_sel, RREADY_sel, RLAST_sel, wr_busy_slv,
    output rd_grant_vld, rd_grant_mst, rd_grant_slv, rd_grant_oh, rd_timeout
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotating-priority picker, shared by the read and write arbiters.
//   req     : request vector
//   ptr     : last winner; search starts at ptr+1 modulo N
//   gnt_oh  : one-hot winner
//   gnt_idx : binary winner index
//   gnt_any : at least one request present
// Fixed priority (lowest index first) is obtained by driving ptr = N-1.
module rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_oh,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);

  // Walk from the farthest candidate to the nearest so the nearest request overwrites.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = W'(idx);
        gnt_any     = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter_param.sv
// axi_rd_arbiter_param
// Read-address arbiter for the AXI crossbar: NUM_M masters, NUM_S slaves plus a
// DECERR default slave. Owns the read grant from AR acceptance to the RLAST handshake.
//   ACLK / ARESET : clock, asynchronous active-high reset
//   bus (slave)   : AR requests, muxed ARREADY/R handshakes, per-slave write busy in;
//                   registered grant (vld/mst/slv/oh) and watchdog pulse out
// ADDR_W must not exceed 32 (width of the decode table entries).
module axi_rd_arbiter_param
  import axi_arb_pkg::*;
#(
  parameter int NUM_M       = 3,
  parameter int NUM_S       = 8,
  parameter int ADDR_W      = 32,
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic ACLK,
  input logic ARESET,
  axi_rd_arbiter_param_if.slave bus
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = $clog2(NUM_S + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam int WDW = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  // Lowest matching slave wins; unmatched addresses go to the default slave at NUM_S.
  function automatic logic [SW-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SW-1:0] slv;
    slv = SW'(NUM_S);
    for (int s = NUM_S - 1; s >= 0; s--) begin
      if ((addr & ADDR_W'(SLV_MASK[s])) == ADDR_W'(SLV_BASE[s])) begin
        slv = SW'(s);
      end
    end
    return slv;
  endfunction

  arb_state_e        state_r;
  logic [MW-1:0]     rr_ptr_r;
  logic [WDW-1:0]    wdog_r;
  logic              vld_r;
  logic [MW-1:0]     mst_r;
  logic [SW-1:0]     slv_r;
  logic [NUM_M-1:0]  oh_r;
  logic              timeout_r;

  logic [SW-1:0]     dec_s [NUM_M];
  logic [NUM_M-1:0]  elig_s;
  logic [MW-1:0]     pick_ptr_s;
  logic [NUM_M-1:0]  pick_oh_s;
  logic [MW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic              rlast_hs_s;
  logic              wdog_exp_s;

  // Per-master decode and eligibility: a master whose target is write-busy drops out.
  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      dec_s[i]  = decode(bus.ARADDR_M[i*ADDR_W +: ADDR_W]);
      elig_s[i] = bus.ARVALID_M[i] && !bus.wr_busy_slv[dec_s[i]];
    end
  end

  // Fixed priority reuses the rotating picker with the pointer parked at the top index.
  always_comb begin
    if (ARB_MODE == ARB_RR) begin
      pick_ptr_s = rr_ptr_r;
    end else begin
      pick_ptr_s = MW'(NUM_M - 1);
    end
  end

  rr_pick #(.N(NUM_M), .W(MW)) u_pick (
    .req     (elig_s),
    .ptr     (pick_ptr_s),
    .gnt_oh  (pick_oh_s),
    .gnt_idx (pick_idx_s),
    .gnt_any (pick_any_s)
  );

  assign rlast_hs_s = bus.RVALID_sel && bus.RREADY_sel && bus.RLAST_sel;
  assign wdog_exp_s = (TIMEOUT_CYC != 0) && (wdog_r == WDW'(TO_LAST));

  // Arbiter FSM with registered grant outputs; RLAST takes precedence over watchdog expiry.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r   <= IDLE;
      rr_ptr_r  <= MW'(NUM_M - 1);
      wdog_r    <= '0;
      vld_r     <= 1'b0;
      mst_r     <= '0;
      slv_r     <= '0;
      oh_r      <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            state_r <= ADDR;
            vld_r   <= 1'b1;
            mst_r   <= pick_idx_s;
            oh_r    <= pick_oh_s;
            slv_r   <= dec_s[pick_idx_s];
            if (ARB_MODE == ARB_RR) begin
              rr_ptr_r <= pick_idx_s;
            end else begin
              rr_ptr_r <= rr_ptr_r;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ADDR: begin
          if (bus.ARREADY_sel) begin
            state_r <= DATA;
            wdog_r  <= '0;
          end else begin
            state_r <= ADDR;
          end
        end
        DATA: begin
          if (rlast_hs_s || wdog_exp_s) begin
            state_r   <= IDLE;
            vld_r     <= 1'b0;
            mst_r     <= '0;
            slv_r     <= '0;
            oh_r      <= '0;
            timeout_r <= !rlast_hs_s;
          end else begin
            wdog_r <= wdog_r + WDW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          vld_r   <= 1'b0;
          mst_r   <= '0;
          slv_r   <= '0;
          oh_r    <= '0;
        end
      endcase
    end
  end

  assign bus.rd_grant_vld = vld_r;
  assign bus.rd_grant_mst = mst_r;
  assign bus.rd_grant_slv = slv_r;
  assign bus.rd_grant_oh  = oh_r;
  assign bus.rd_timeout   = timeout_r;

endmodule

// File: tb/tb_axi_rd_arbiter_param.sv
// tb_axi_rd_arbiter_param
// Directed bench: a round-robin instance (TIMEOUT_CYC=16) and a fixed-priority
// instance (TIMEOUT_CYC=16) share clock and reset.
module tb_axi_rd_arbiter_param;

  logic ACLK;
  logic ARESET;
  int   checks;
  int   failures;

  axi_rd_arbiter_param_if #(.NUM_M(3), .NUM_S(8), .ADDR_W(32)) if_rr ();
  axi_rd_arbiter_param_if #(.NUM_M(3), .NUM_S(8), .ADDR_W(32)) if_fx ();

  axi_rd_arbiter_param #(.NUM_M(3), .NUM_S(8), .ADDR_W(32), .ARB_MODE(1), .TIMEOUT_CYC(16))
    dut_rr (.ACLK(ACLK), .ARESET(ARESET), .bus(if_rr));

  axi_rd_arbiter_param #(.NUM_M(3), .NUM_S(8), .ADDR_W(32), .ARB_MODE(0), .TIMEOUT_CYC(16))
    dut_fx (.ACLK(ACLK), .ARESET(ARESET), .bus(if_fx));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic wait_gnt_rr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      if (if_rr.rd_grant_vld === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gnt_fx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      if (if_fx.rd_grant_vld === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle_rr();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (if_rr.rd_grant_vld === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_wait got=busy exp=idle within 40 cycles");
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({if_rr.rd_grant_vld, if_rr.rd_grant_mst, if_rr.rd_grant_slv, if_rr.rd_grant_oh, if_rr.rd_timeout} !== 11'd0) begin
      failures++;
      $display("FAIL reset_rr_outputs got=%b exp=0", {if_rr.rd_grant_vld, if_rr.rd_grant_mst, if_rr.rd_grant_slv, if_rr.rd_grant_oh, if_rr.rd_timeout});
    end
    checks++;
    if ({if_fx.rd_grant_vld, if_fx.rd_grant_mst, if_fx.rd_grant_slv, if_fx.rd_grant_oh, if_fx.rd_timeout} !== 11'd0) begin
      failures++;
      $display("FAIL reset_fx_outputs got=%b exp=0", {if_fx.rd_grant_vld, if_fx.rd_grant_mst, if_fx.rd_grant_slv, if_fx.rd_grant_oh, if_fx.rd_timeout});
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if (if_rr.rd_grant_vld !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=0", if_rr.rd_grant_vld);
    end
  endtask

  task automatic test_rr_rotation();
    int         exp_m [4] = '{0, 1, 2, 0};
    logic [2:0] eoh;
    bit         ok;
    if_rr.ARADDR_M    = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    if_rr.ARREADY_sel = 1'b1;
    if_rr.RVALID_sel  = 1'b1;
    if_rr.RREADY_sel  = 1'b1;
    if_rr.RLAST_sel   = 1'b1;
    if_rr.ARVALID_M   = 3'b111;
    for (int b = 0; b < 4; b++) begin
      wait_gnt_rr(ok);
      eoh = 3'(1 << exp_m[b]);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_grant_timeout burst=%0d got=none exp=grant", b);
      end else begin
        if (if_rr.rd_grant_mst !== 2'(exp_m[b])) begin
          failures++;
          $display("FAIL rr_mst burst=%0d got=%0d exp=%0d", b, if_rr.rd_grant_mst, exp_m[b]);
        end
        checks++;
        if (if_rr.rd_grant_oh !== eoh) begin
          failures++;
          $display("FAIL rr_oh burst=%0d got=%b exp=%b", b, if_rr.rd_grant_oh, eoh);
        end
        checks++;
        if (if_rr.rd_grant_slv !== 4'd1) begin
          failures++;
          $display("FAIL rr_slv burst=%0d got=%0d exp=1", b, if_rr.rd_grant_slv);
        end
      end
      @(negedge ACLK);
      @(negedge ACLK);
      checks++;
      if (if_rr.rd_grant_vld !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle_gap burst=%0d got=%b exp=0", b, if_rr.rd_grant_vld);
      end
      if (b == 3) begin
        if_rr.ARVALID_M = 3'b000;
      end
    end
  endtask

  task automatic test_fixed_priority();
    bit ok;
    if_fx.ARADDR_M    = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    if_fx.ARREADY_sel = 1'b1;
    if_fx.RVALID_sel  = 1'b1;
    if_fx.RREADY_sel  = 1'b1;
    if_fx.RLAST_sel   = 1'b1;
    if_fx.ARVALID_M   = 3'b111;
    for (int b = 0; b < 4; b++) begin
      wait_gnt_fx(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL fx_grant_timeout burst=%0d got=none exp=grant", b);
      end else if (if_fx.rd_grant_mst !== 2'd0 || if_fx.rd_grant_oh !== 3'b001) begin
        failures++;
        $display("FAIL fx_mst burst=%0d got=%0d/%b exp=0/001", b, if_fx.rd_grant_mst, if_fx.rd_grant_oh);
      end
      @(negedge ACLK);
      @(negedge ACLK);
      if (b == 3) begin
        if_fx.ARVALID_M = 3'b000;
      end
    end
  endtask

  task automatic test_write_interlock();
    bit ok;
    wait_idle_rr();
    if_rr.ARADDR_M    = {32'h0000_0000, 32'h0000_0010, 32'h0002_0004};
    if_rr.wr_busy_slv = 9'b0_0000_0100;
    if_rr.ARVALID_M   = 3'b011;
    wait_gnt_rr(ok);
    checks++;
    if (!ok || if_rr.rd_grant_mst !== 2'd1 || if_rr.rd_grant_slv !== 4'd0) begin
      failures++;
      $display("FAIL busy_bypass got=vld%0d mst%0d slv%0d exp=vld1 mst1 slv0", ok, if_rr.rd_grant_mst, if_rr.rd_grant_slv);
    end
    @(negedge ACLK);
    if_rr.ARVALID_M   = 3'b001;
    if_rr.wr_busy_slv = 9'd0;
    wait_gnt_rr(ok);
    if_rr.ARVALID_M = 3'b000;
    checks++;
    if (!ok || if_rr.rd_grant_mst !== 2'd0 || if_rr.rd_grant_slv !== 4'd2 || if_rr.rd_grant_oh !== 3'b001) begin
      failures++;
      $display("FAIL busy_cleared got=vld%0d mst%0d slv%0d exp=vld1 mst0 slv2", ok, if_rr.rd_grant_mst, if_rr.rd_grant_slv);
    end
  endtask

  task automatic test_decode_error();
    bit ok;
    wait_idle_rr();
    if_rr.ARREADY_sel = 1'b0;
    if_rr.ARADDR_M    = {32'h4000_0000, 32'h0000_0000, 32'h0000_0000};
    if_rr.ARVALID_M   = 3'b100;
    wait_gnt_rr(ok);
    if_rr.ARVALID_M = 3'b000;
    checks++;
    if (!ok || if_rr.rd_grant_mst !== 2'd2 || if_rr.rd_grant_slv !== 4'd8) begin
      failures++;
      $display("FAIL decerr_grant got=vld%0d mst%0d slv%0d exp=vld1 mst2 slv8", ok, if_rr.rd_grant_mst, if_rr.rd_grant_slv);
    end
    @(negedge ACLK);
    checks++;
    if (if_rr.rd_grant_vld !== 1'b1 || if_rr.rd_grant_slv !== 4'd8) begin
      failures++;
      $display("FAIL addr_hold got=vld%0d slv%0d exp=vld1 slv8", if_rr.rd_grant_vld, if_rr.rd_grant_slv);
    end
    if_rr.ARREADY_sel = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    checks++;
    if (if_rr.rd_grant_vld !== 1'b0 || if_rr.rd_grant_slv !== 4'd0 || if_rr.rd_grant_oh !== 3'b000) begin
      failures++;
      $display("FAIL decerr_release got=vld%0d slv%0d oh%b exp=vld0 slv0 oh000", if_rr.rd_grant_vld, if_rr.rd_grant_slv, if_rr.rd_grant_oh);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int hit;
    wait_idle_rr();
    if_rr.RVALID_sel  = 1'b0;
    if_rr.RREADY_sel  = 1'b0;
    if_rr.RLAST_sel   = 1'b0;
    if_rr.ARREADY_sel = 1'b0;
    if_rr.ARADDR_M    = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    if_rr.ARVALID_M   = 3'b001;
    wait_gnt_rr(ok);
    if_rr.ARVALID_M   = 3'b000;
    if_rr.ARREADY_sel = 1'b1;
    @(negedge ACLK);
    hit = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge ACLK);
      if (if_rr.rd_timeout === 1'b1) begin
        hit = k;
        break;
      end
    end
    checks++;
    if (hit != 16) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=16", hit);
    end
    checks++;
    if (if_rr.rd_grant_vld !== 1'b0) begin
      failures++;
      $display("FAIL timeout_release got=%b exp=0", if_rr.rd_grant_vld);
    end
    @(negedge ACLK);
    checks++;
    if (if_rr.rd_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_width got=%b exp=0", if_rr.rd_timeout);
    end
    // RLAST arriving on the expiry cycle completes normally.
    wait_idle_rr();
    if_rr.ARREADY_sel = 1'b0;
    if_rr.ARVALID_M   = 3'b001;
    wait_gnt_rr(ok);
    if_rr.ARVALID_M   = 3'b000;
    if_rr.ARREADY_sel = 1'b1;
    @(negedge ACLK);
    repeat (15) @(negedge ACLK);
    checks++;
    if (if_rr.rd_grant_vld !== 1'b1 || if_rr.rd_timeout !== 1'b0) begin
      failures++;
      $display("FAIL pre_expiry got=vld%0d to%0d exp=vld1 to0", if_rr.rd_grant_vld, if_rr.rd_timeout);
    end
    if_rr.RVALID_sel = 1'b1;
    if_rr.RREADY_sel = 1'b1;
    if_rr.RLAST_sel  = 1'b1;
    @(negedge ACLK);
    checks++;
    if (if_rr.rd_timeout !== 1'b0 || if_rr.rd_grant_vld !== 1'b0) begin
      failures++;
      $display("FAIL rlast_at_expiry got=to%0d vld%0d exp=to0 vld0", if_rr.rd_timeout, if_rr.rd_grant_vld);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_idle_rr();
    if_rr.RVALID_sel  = 1'b0;
    if_rr.RREADY_sel  = 1'b0;
    if_rr.RLAST_sel   = 1'b0;
    if_rr.ARREADY_sel = 1'b1;
    if_rr.ARVALID_M   = 3'b010;
    wait_gnt_rr(ok);
    if_rr.ARVALID_M = 3'b000;
    @(negedge ACLK);
    checks++;
    if (if_rr.rd_grant_vld !== 1'b1 || if_rr.rd_grant_mst !== 2'd1) begin
      failures++;
      $display("FAIL pre_reset_data got=vld%0d mst%0d exp=vld1 mst1", if_rr.rd_grant_vld, if_rr.rd_grant_mst);
    end
    #2;
    ARESET = 1'b1;
    #1;
    checks++;
    if ({if_rr.rd_grant_vld, if_rr.rd_grant_mst, if_rr.rd_grant_slv, if_rr.rd_grant_oh, if_rr.rd_timeout} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0", {if_rr.rd_grant_vld, if_rr.rd_grant_mst, if_rr.rd_grant_slv, if_rr.rd_grant_oh, if_rr.rd_timeout});
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    if_rr.RVALID_sel = 1'b1;
    if_rr.RREADY_sel = 1'b1;
    if_rr.RLAST_sel  = 1'b1;
    if_rr.ARVALID_M  = 3'b111;
    wait_gnt_rr(ok);
    if_rr.ARVALID_M = 3'b000;
    checks++;
    if (!ok || if_rr.rd_grant_mst !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_first got=vld%0d mst%0d exp=vld1 mst0", ok, if_rr.rd_grant_mst);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ARESET   = 1'b1;
    if_rr.ARVALID_M = '0; if_rr.ARADDR_M = '0; if_rr.ARREADY_sel = 1'b0;
    if_rr.RVALID_sel = 1'b0; if_rr.RREADY_sel = 1'b0; if_rr.RLAST_sel = 1'b0;
    if_rr.wr_busy_slv = '0;
    if_fx.ARVALID_M = '0; if_fx.ARADDR_M = '0; if_fx.ARREADY_sel = 1'b0;
    if_fx.RVALID_sel = 1'b0; if_fx.RREADY_sel = 1'b0; if_fx.RLAST_sel = 1'b0;
    if_fx.wr_busy_slv = '0;
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_write_interlock();
    test_decode_error();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_param.md
Name: axi_rd_arbiter_param

Overview:
Parametrised read-address arbiter for the AXI crossbar. It generalises the existing fixed 3-master/8-slave read arbiter to NUM_M masters and NUM_S slaves, with a table-driven address decode and a selectable fixed-priority or round-robin policy. It adds per-slave write-interlock and a burst watchdog. It owns the read-path grant from AR acceptance through the RLAST handshake; the crossbar muxes AR/R channels using its registered grant outputs.

Parameters:
NUM_M, 3, number of read masters (2..8)
NUM_S, 8, number of real slaves; index NUM_S is the default (DECERR) slave
ADDR_W, 32, address width
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT_CYC, 1024, max cycles in DATA state before forced release; 0 disables
MW, $clog2(NUM_M), master index width (derived)
SW, $clog2(NUM_S+1), slave index width (derived)

Ports:
ACLK  in  1  clock
ARESET  in  1  async active-high reset
ARVALID_M  in  NUM_M  per-master ARVALID
ARADDR_M  in  NUM_M*ADDR_W  packed per-master ARADDR, master i at [i*ADDR_W +: ADDR_W]
ARREADY_sel  in  1  ARREADY of the currently granted slave (muxed by crossbar)
RVALID_sel  in  1  RVALID on the granted path
RREADY_sel  in  1  RREADY on the granted path
RLAST_sel  in  1  RLAST on the granted path
wr_busy_slv  in  NUM_S+1  slave currently owned by write arbiter
rd_grant_vld  out  1  grant active (ADDR or DATA state)
rd_grant_mst  out  MW  granted master index
rd_grant_slv  out  SW  granted slave index
rd_grant_oh  out  NUM_M  one-hot granted master
rd_timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Clock and reset: one clock ACLK. Reset ARESET is asynchronous, active-high. While reset is asserted, including mid-burst, all state clears immediately.
- Reset values: state = IDLE; all outputs 0; RR pointer = NUM_M-1 so master 0 has first priority; watchdog = 0.
- Decode: each slave s has BASE[s]/MASK[s] from the package. Match when (addr & MASK) == BASE. The lowest matching s wins. No match selects NUM_S (default slave).
- Eligibility: eligible[i] = ARVALID_M[i] && !wr_busy_slv[decode(ARADDR_M[i])].
- FSM: IDLE -> ADDR -> DATA -> IDLE.
  - IDLE: if any eligible master, choose the winner by ARB_MODE. Register winner and decoded slave; go to ADDR. Grant outputs are valid the cycle after ARVALID (latency 1).
  - ARB_MODE=1: search starts at pointer+1 modulo NUM_M. The pointer is updated to the winner on the IDLE->ADDR transition.
  - ADDR: hold grant. On ARREADY_sel=1, go to DATA and clear the watchdog. If ARVALID drops while in ADDR, the grant is still held.
  - DATA: on RVALID_sel && RREADY_sel && RLAST_sel, go to IDLE. Otherwise increment the watchdog.
  - Watchdog: if TIMEOUT_CYC != 0 and watchdog == TIMEOUT_CYC-1 without RLAST, pulse rd_timeout and go to IDLE.
  - An RLAST handshake in the same cycle as timeout expiry is a normal completion; no rd_timeout pulse.
- Minimum one IDLE cycle between bursts; no back-to-back grant in the RLAST cycle.
- Grant outputs only change on FSM transitions; inputs never pass combinationally to outputs.
- A blocked master (its target slave is write-busy) does not block lower-priority eligible masters.
- Decode-error grants go to slave NUM_S and otherwise follow the normal FSM.

Decomposition:
- Package axi_arb_pkg: SLV_BASE/SLV_MASK arrays, DEFAULT_SLV = NUM_S, arb_state_e enum {IDLE, ADDR, DATA}, ARB_FIXED/ARB_RR constants.
- Sub-module rr_pick: combinational request vector + pointer -> one-hot winner and index. Also used by the write arbiter.

Test Plan:
1. ARB_MODE=1; ARVALID_M=3'b111 held, all ADDR 0x0001_0000, ARREADY/RLAST immediate -> grants in order M0, M1, M2, M0; rd_grant_slv=1 each time.
2. ARB_MODE=0; same stimulus -> M0 granted every burst; M1/M2 never granted while M0 keeps requesting.
3. M0 requests 0x0002_0004 with wr_busy_slv[2]=1, M1 requests 0x0000_0010 -> M1 granted with slv=0. Clear busy -> M0 granted with slv=2 on next arbitration.
4. M2 requests 0x4000_0000 -> rd_grant_slv=NUM_S (8); RLAST handshake returns FSM to IDLE; rd_grant_vld=0 the next cycle.
5. TIMEOUT_CYC=16; grant, ARREADY, never RLAST -> rd_timeout pulses exactly 1 cycle, 16 cycles after DATA entry; grant clears. Repeat with RLAST on the expiry cycle -> no pulse.
6. Assert ARESET mid-DATA (between clock edges) -> all outputs 0 asynchronously. After release, M0 is granted first in RR mode.
